// File: rtl/mux_sel_scanner.sv
// rtl/mux_sel_scanner.sv - steps a 4:1 mux select through all channels, samples F after a dwell, hands off a 4-bit word
// Optional: define CONTINUOUS_SCAN_EN to restart a scan on every handshake instead of returning to IDLE.
module mux_sel_scanner #(
    parameter int DWELL = 4,
    parameter int CNT_W = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mux_f,
    output logic [1:0] Sel,
    output logic       busy,
    output logic [3:0] word,
    output logic       valid,
    input  logic       ready
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       word_q, word_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= 2'b00;
            word_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        word_d  = word_q;
        case (state_q)
            IDLE: begin
                sel_d = 2'b00;
                if (start) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                // Hold the counter on the last dwell cycle so DWELL == 2^CNT_W never wraps.
                if (cnt_q == CNT_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SAMPLE: begin
                word_d[sel_q] = mux_f;
                if (sel_q != 2'b11) begin
                    sel_d   = sel_q + 2'd1;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ready) begin
                    sel_d = 2'b00;
                    cnt_d = '0;
`ifdef CONTINUOUS_SCAN_EN
                    state_d = SETTLE;
`else
                    state_d = IDLE;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Sel   = sel_q;
    assign busy  = (state_q != IDLE);
    assign valid = (state_q == DONE);
    assign word  = word_q;

endmodule

// File: tb/tb_mux_sel_scanner.sv
// tb/tb_mux_sel_scanner.sv - randomized self-checking bench for mux_sel_scanner with a behavioural scan model
module tb_mux_sel_scanner;

    localparam int D0 = 4;
    localparam int D1 = 1;
    localparam int D2 = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_v [3];
    logic       ready_v [3];
    logic [3:0] chan    [3];
    logic       mux_f_w [3];
    logic [1:0] sel_w   [3];
    logic       busy_w  [3];
    logic [3:0] word_w  [3];
    logic       valid_w [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Behavioural 4:1 mux per instance: channel k appears on F when Sel == k.
    assign mux_f_w[0] = chan[0][sel_w[0]];
    assign mux_f_w[1] = chan[1][sel_w[1]];
    assign mux_f_w[2] = chan[2][sel_w[2]];

    mux_sel_scanner #(.DWELL(D0), .CNT_W(3)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .mux_f(mux_f_w[0]), .Sel(sel_w[0]),
        .busy(busy_w[0]), .word(word_w[0]), .valid(valid_w[0]), .ready(ready_v[0])
    );
    mux_sel_scanner #(.DWELL(D1), .CNT_W(3)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .mux_f(mux_f_w[1]), .Sel(sel_w[1]),
        .busy(busy_w[1]), .word(word_w[1]), .valid(valid_w[1]), .ready(ready_v[1])
    );
    mux_sel_scanner #(.DWELL(D2), .CNT_W(3)) dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .mux_f(mux_f_w[2]), .Sel(sel_w[2]),
        .busy(busy_w[2]), .word(word_w[2]), .valid(valid_w[2]), .ready(ready_v[2])
    );

    function automatic int dw(input int idx);
        case (idx)
            0:       return D0;
            1:       return D1;
            default: return D2;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (sel_w[i] !== 2'b00 || busy_w[i] !== 1'b0 || valid_w[i] !== 1'b0 || word_w[i] !== 4'b0000) begin
                errors++;
                $display("FAIL reset idx=%0d got sel=%b busy=%b valid=%b word=%b exp sel=00 busy=0 valid=0 word=0000",
                         i, sel_w[i], busy_w[i], valid_w[i], word_w[i]);
            end
        end
    endtask

    // One full scan on instance idx; the model predicts Sel per cycle and captures each channel at its sampling edge.
    task automatic run_scan(input int idx, input logic [3:0] fixed, input bit rnd, input bit noise, input int hold);
        int d, l;
        logic [3:0] expw;
        d = dw(idx);
        l = 4 * (d + 1);
        expw = 4'b0000;
        chan[idx] = rnd ? 4'($urandom) : fixed;
        ready_v[idx] = 1'b0;
        start_v[idx] = 1'b1;
        step();
        start_v[idx] = 1'b0;
        for (int t = 0; t < l; t++) begin
            checks++;
            if (sel_w[idx] !== 2'(t / (d + 1)) || busy_w[idx] !== 1'b1 || valid_w[idx] !== 1'b0) begin
                errors++;
                $display("FAIL scan_seq idx=%0d t=%0d got sel=%0d busy=%b valid=%b exp sel=%0d busy=1 valid=0",
                         idx, t, sel_w[idx], busy_w[idx], valid_w[idx], t / (d + 1));
            end
            if (rnd) chan[idx] = 4'($urandom);
            start_v[idx] = noise && (t == 2 || t == 11);
            ready_v[idx] = noise && (t == l - 3);
            if ((t + 1) % (d + 1) == 0) expw[(t + 1) / (d + 1) - 1] = chan[idx][(t + 1) / (d + 1) - 1];
            step();
        end
        start_v[idx] = 1'b0;
        ready_v[idx] = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            checks++;
            if (valid_w[idx] !== 1'b1 || word_w[idx] !== expw || sel_w[idx] !== 2'b11 || busy_w[idx] !== 1'b1) begin
                errors++;
                $display("FAIL scan_done idx=%0d hold=%0d got valid=%b word=%b sel=%b busy=%b exp valid=1 word=%b sel=11 busy=1",
                         idx, h, valid_w[idx], word_w[idx], sel_w[idx], busy_w[idx], expw);
            end
            if (rnd) chan[idx] = 4'($urandom);
            if (h < hold) step();
        end
        ready_v[idx] = 1'b1;
        step();
        ready_v[idx] = 1'b0;
        checks++;
        if (valid_w[idx] !== 1'b0 || busy_w[idx] !== 1'b0 || sel_w[idx] !== 2'b00 || word_w[idx] !== expw) begin
            errors++;
            $display("FAIL scan_return idx=%0d got valid=%b busy=%b sel=%b word=%b exp valid=0 busy=0 sel=00 word=%b",
                     idx, valid_w[idx], busy_w[idx], sel_w[idx], word_w[idx], expw);
        end
    endtask

    task automatic test_reset_mid_scan();
        int d;
        d = dw(0);
        chan[0] = 4'b1111;
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        for (int t = 0; t < 2 * (d + 1); t++) step();
        checks++;
        if (sel_w[0] !== 2'b10) begin
            errors++;
            $display("FAIL mid_scan_sel got=%b exp=10", sel_w[0]);
        end
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (sel_w[0] !== 2'b00 || busy_w[0] !== 1'b0 || valid_w[0] !== 1'b0 || word_w[0] !== 4'b0000) begin
                errors++;
                $display("FAIL mid_scan_reset cyc=%0d got sel=%b busy=%b valid=%b word=%b exp sel=00 busy=0 valid=0 word=0000",
                         i, sel_w[0], busy_w[0], valid_w[0], word_w[0]);
            end
            step();
        end
        run_scan(0, 4'b0110, 1'b0, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        int l, c, r1, r2;
        logic prev;
        l = 4 * (dw(1) + 1);
        c = 0;
        r1 = -1;
        r2 = -1;
        prev = 1'b0;
        chan[1] = 4'b1010;
        start_v[1] = 1'b1;
        ready_v[1] = 1'b1;
        for (int i = 0; i < 6 * l && r2 < 0; i++) begin
            step();
            c++;
            if (valid_w[1] && !prev) begin
                if (r1 < 0) r1 = c;
                else r2 = c;
            end
            prev = valid_w[1];
        end
        start_v[1] = 1'b0;
        checks++;
        if (r1 != l + 1 || r2 - r1 != l + 2) begin
            errors++;
            $display("FAIL back_to_back got first=%0d period=%0d exp first=%0d period=%0d", r1, r2 - r1, l + 1, l + 2);
        end
        checks++;
        if (word_w[1] !== 4'b1010) begin
            errors++;
            $display("FAIL back_to_back_word got=%b exp=1010", word_w[1]);
        end
        for (int i = 0; i < 2 * l && busy_w[1]; i++) step();
        ready_v[1] = 1'b0;
        checks++;
        if (busy_w[1] !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_idle got busy=%b exp 0", busy_w[1]);
        end
    endtask

    task automatic test_continuous();
        int l, c, n;
        int rise [3];
        logic prev;
        l = 4 * (dw(0) + 1);
        c = 0;
        n = 0;
        prev = 1'b0;
        chan[0] = 4'b1101;
        ready_v[0] = 1'b1;
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        for (int i = 0; i < 5 * l && n < 3; i++) begin
            if (valid_w[0] && !prev) begin
                rise[n] = c;
                checks++;
                if (word_w[0] !== ((n == 0) ? 4'b1101 : 4'b0101)) begin
                    errors++;
                    $display("FAIL cont_word n=%0d got=%b exp=%b", n, word_w[0], (n == 0) ? 4'b1101 : 4'b0101);
                end
                if (n == 0) chan[0] = 4'b0101;
                n++;
            end
            prev = valid_w[0];
            step();
            c++;
        end
        checks++;
        if (n < 3 || rise[0] != l || rise[1] - rise[0] != l + 1 || rise[2] - rise[1] != l + 1) begin
            errors++;
            $display("FAIL cont_timing got pulses=%0d first=%0d p1=%0d p2=%0d exp pulses=3 first=%0d period=%0d",
                     n, rise[0], rise[1] - rise[0], rise[2] - rise[1], l, l + 1);
        end
        checks++;
        if (busy_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL cont_busy got=%b exp=1", busy_w[0]);
        end
        ready_v[0] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            ready_v[i] = 1'b0;
            chan[i]    = 4'b0000;
        end
        test_reset();
`ifdef CONTINUOUS_SCAN_EN
        test_continuous();
`else
        run_scan(0, 4'b1101, 1'b0, 1'b0, 0);
        run_scan(0, 4'b1101, 1'b0, 1'b0, 10);
        run_scan(0, 4'b0000, 1'b1, 1'b1, 3);
        test_reset_mid_scan();
        run_scan(1, 4'b1010, 1'b0, 1'b0, 0);
        for (int k = 0; k < 4; k++) run_scan(1, 4'b0000, 1'b1, 1'b0, k);
        run_scan(2, 4'b0000, 1'b1, 1'b0, 2);
        run_scan(2, 4'b0000, 1'b1, 1'b1, 0);
        test_back_to_back();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_sel_scanner.md
Name: mux_sel_scanner

Overview:
- Sequencer that sits directly upstream of the 4:1 mux (mux_4t1a / mux_4t1b).
- Drives the mux select lines through all four channels in order and waits a programmable settle time on each one.
- Samples the mux output F back in and assembles the four sampled bits into a 4-bit word.
- Hands the word downstream with a valid/ready handshake.

Parameters:
- DWELL, 4: settle cycles per channel before sampling; legal range is 1 to 2^CNT_W.
- CNT_W, 3: width of the dwell counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle scan request; sampled only in IDLE.
- mux_f  input  1  F output of the downstream mux.
- Sel  output  [1:0]  mux select; connects directly to the mux Sel port.
- busy  output  1  high while a scan is in progress or a result is pending.
- word  output  [3:0]  assembled sample word; word[k] holds F sampled with Sel==k.
- valid  output  1  word is complete and stable.
- ready  input  1  downstream accepts word.

Behaviour:
- Reset: rst is sampled on the rising edge of clk.
  - State goes to IDLE.
  - Sel=2'b00, busy=0, valid=0, word=4'b0000, counter=0.
  - Reset takes priority over every other input, including in the middle of a scan and in DONE. A pending word is discarded.
- State machine: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - Sel held at 00, busy=0, valid=0.
  - start=1 → SETTLE, with counter=0, Sel=00, busy=1.
  - word keeps its previous value until it is overwritten.
- SETTLE:
  - counter increments by 1 per cycle.
  - When counter==DWELL-1 → SAMPLE.
  - SETTLE therefore lasts exactly DWELL cycles. DWELL=1 gives one cycle.
- SAMPLE (one cycle):
  - word[Sel] <= mux_f.
  - If Sel≠11: Sel <= Sel+1, counter <= 0, → SETTLE.
  - If Sel==11: → DONE. Sel stays at 11 until the handshake.
- DONE:
  - valid=1, busy=1, word held stable.
  - A handshake is valid&&ready in the same cycle. On the handshake: → IDLE, valid=0, busy=0, Sel=00 on the next cycle.
  - ready while valid=0 is ignored.
- start outside IDLE is ignored. No queuing, no restart.
- Sel changes only on the SAMPLE→SETTLE and DONE→IDLE transitions. The mux input is never sampled in the same cycle that Sel changes.
- Latency:
  - start sampled at edge E0 → valid observed high after edge E0+4*(DWELL+1).
  - With DWELL=4 that is 20 cycles.
  - Minimum start-to-start period is 4*(DWELL+1)+2 cycles with ready tied high.
- Counter arithmetic:
  - CNT_W-bit unsigned.
  - The comparison against DWELL-1 is done at CNT_W width.
  - The counter never wraps, because DWELL ≤ 2^CNT_W.

Optional Feature:
- Macro: CONTINUOUS_SCAN_EN.
- Defined:
  - On the handshake in DONE, the state goes directly to SETTLE with Sel=00, counter=0, valid=0, busy=1.
  - No start is needed for the next scan; scanning repeats until rst.
  - start is ignored after the first scan begins.
- Undefined: DONE returns to IDLE as described in Behaviour.

Test Plan:
- Reset: assert rst for 2 cycles mid-scan (Sel=10) → next cycle Sel=00, busy=0, valid=0, word=0000; state IDLE, and a later start produces a full scan.
- Basic scan:
  - Setup: DWELL=4, mux channel inputs A=1, B=0, C=1, D=1, ready=1, single start pulse.
  - Sel sequence: Sel steps 00→01→10→11, each held 5 cycles.
  - Result: valid high 20 cycles after the start edge, word=4'b1101.
  - Return: IDLE one cycle after the handshake.
- Backpressure: ready=0 for 10 cycles after valid rises → valid and word=1101 stay constant, Sel=11, busy=1; ready=1 → valid drops next cycle.
- Ignored start:
  - start pulses at cycles 3 and 12 of a scan → a single scan only, with no timing shift.
  - ready pulse before valid → no effect.
- Minimum dwell: DWELL=1, alternate inputs 0,1,0,1 → valid at 8 cycles after start, word=4'b1010.
- CONTINUOUS_SCAN_EN defined, ready=1, one start → valid pulses every 4*(DWELL+1)+1 cycles; change D from 1 to 0 mid-run → the next complete word reflects word[3]=0.
